// File: rtl/instr_issuer.sv
// Instruction-side initiator for simple_cpu: replays a small program store onto the
// CPU instruction port, holding each word for the CU cycle count of its class.
module instr_issuer #(
  parameter int INSTR_WIDTH    = 20,
  parameter int PROG_ADDR_BITS = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [PROG_ADDR_BITS-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]    load_data,
  input  logic                      start,
  output logic [INSTR_WIDTH-1:0]    instr_out,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      retired
);

  localparam int DEPTH  = 2 ** PROG_ADDR_BITS;
  localparam int HOLD_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
  logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [CNT_WIDTH-1:0]      retired_q, retired_d;

  logic [INSTR_WIDTH-1:0]    mem [DEPTH];

  logic                      accept_cmd;
  logic                      wr_en;
  logic [INSTR_WIDTH-1:0]    first_instr;
  logic [PROG_ADDR_BITS-1:0] next_addr;
  logic [INSTR_WIDTH-1:0]    next_instr;
  logic                      last_pc;

  // Hold length in edges per class; HALT (00) is never issued.
  function automatic logic [HOLD_W-1:0] hold_len(input logic [INSTR_WIDTH-1:0] instr);
    logic [HOLD_W-1:0] len;
    unique case (instr[INSTR_WIDTH-1 -: 2])
      2'b01:   len = HOLD_W'(3);
      2'b10:   len = HOLD_W'(4);
      2'b11:   len = HOLD_W'(3);
      default: len = '0;
    endcase
    return len;
  endfunction

  function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] instr);
    return instr[INSTR_WIDTH-1 -: 2] == 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    accept_cmd  = (state_q == S_IDLE) || (state_q == S_DONE);
    wr_en       = load_en && accept_cmd;
    // A same-edge write to address 0 must be visible to the start it races with.
    first_instr = (wr_en && (load_addr == '0)) ? load_data : mem[0];
    next_addr   = pc_q + PROG_ADDR_BITS'(1);
    next_instr  = mem[next_addr];
    last_pc     = &pc_q;
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    retired_d = retired_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_d      = '0;
          retired_d = '0;
          if (is_halt(first_instr)) begin
            state_d = S_DONE;
            instr_d = '0;
            hold_d  = '0;
          end else begin
            state_d = S_PRIME;
            instr_d = first_instr;
            hold_d  = hold_len(first_instr) + HOLD_W'(1);
          end
        end
      end

      S_PRIME, S_ISSUE: begin
        hold_d = hold_q - HOLD_W'(1);
        if (hold_q == HOLD_W'(1)) begin
          retired_d = (&retired_q) ? retired_q : retired_q + CNT_WIDTH'(1);
          if (last_pc || is_halt(next_instr)) begin
            state_d = S_DONE;
            instr_d = '0;
            hold_d  = '0;
          end else begin
            state_d = S_ISSUE;
            pc_d    = next_addr;
            instr_d = next_instr;
            hold_d  = hold_len(next_instr);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      pc_q      <= '0;
      hold_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      retired_q <= retired_d;
    end
  end

  assign instr_out = instr_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign busy      = (state_q == S_PRIME) || (state_q == S_ISSUE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_issuer.sv
// Directed plus randomized checks of instr_issuer against a per-edge expectation list
// derived from the program contents and the class hold lengths.
module tb_instr_issuer;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [3:0]  load_addr;
  logic [19:0] load_data;
  logic        start;
  logic [19:0] instr_out;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
  logic [7:0]  retired;

  int checks = 0;
  int errors = 0;

  logic [19:0] model_mem [16];
  logic [19:0] exp_instr [$];
  int          exp_pc    [$];
  int          exp_ret   [$];

  instr_issuer dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .instr_out (instr_out),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int hold_of(input logic [19:0] w);
    case (w[19:18])
      2'b01:   return 3;
      2'b10:   return 4;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  // Expected observation after each edge following start: each instruction appears
  // for its hold length (first one gets an extra edge), retired counts completed ones.
  task automatic build_model(output int n);
    exp_instr.delete();
    exp_pc.delete();
    exp_ret.delete();
    n = 0;
    for (int i = 0; i < 16; i++) begin
      int h;
      if (model_mem[i][19:18] == 2'b00) break;
      h = hold_of(model_mem[i]) + ((i == 0) ? 1 : 0);
      for (int r = 0; r < h; r++) begin
        exp_instr.push_back(model_mem[i]);
        exp_pc.push_back(i);
        exp_ret.push_back(i);
      end
      n++;
    end
  endtask

  task automatic load_word(input int a, input logic [19:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = 4'(a);
    load_data = d;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic run_prog(input string tag, input bit junk, input bit wr0, input logic [19:0] wr0_data);
    int n;
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin
      load_en   = 1'b1;
      load_addr = 4'd0;
      load_data = wr0_data;
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    load_en = 1'b0;
    if (wr0) model_mem[0] = wr0_data;
    build_model(n);
    $display("run %s: %0d instructions, %0d issue edges", tag, n, exp_instr.size());
    if (junk && n > 0) begin
      load_en   = 1'b1;
      load_addr = 4'd1;
      load_data = 20'h0;
      start     = 1'b1;
    end
    for (int k = 0; k < exp_instr.size(); k++) begin
      chk({tag, " instr"},   32'(instr_out), 32'(exp_instr[k]));
      chk({tag, " pc"},      32'(pc),        32'(exp_pc[k]));
      chk({tag, " retired"}, 32'(retired),   32'(exp_ret[k]));
      chk({tag, " busy"},    32'(busy),      32'd1);
      chk({tag, " done"},    32'(done),      32'd0);
      @(posedge clk);
      #1;
    end
    load_en = 1'b0;
    start   = 1'b0;
    chk({tag, " end done"},    32'(done),      32'd1);
    chk({tag, " end busy"},    32'(busy),      32'd0);
    chk({tag, " end instr"},   32'(instr_out), 32'd0);
    chk({tag, " end pc"},      32'(pc),        32'((n > 0) ? n - 1 : 0));
    chk({tag, " end retired"}, 32'(retired),   32'(n));
    @(posedge clk);
    #1;
    chk({tag, " hold done"},  32'(done),      32'd1);
    chk({tag, " hold instr"}, 32'(instr_out), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " instr"},   32'(instr_out), 32'd0);
    chk({tag, " pc"},      32'(pc),        32'd0);
    chk({tag, " busy"},    32'(busy),      32'd0);
    chk({tag, " done"},    32'(done),      32'd0);
    chk({tag, " retired"}, 32'(retired),   32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    start     = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    #3;
    chk_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_values("idle");

    // Single std_op followed by HALT.
    load_word(0, 20'h49000);
    load_word(1, 20'h00000);
    run_prog("single", 1'b0, 1'b0, 20'h0);

    // Mixed classes; the first run also hammers load/start while busy.
    load_word(0, 20'h49000);
    load_word(1, 20'h8A000);
    load_word(2, 20'hC9000);
    load_word(3, 20'h00000);
    run_prog("mixed_junk", 1'b1, 1'b0, 20'h0);
    run_prog("mixed_readback", 1'b0, 1'b0, 20'h0);

    // Full store: pc must stop at the last address.
    for (int i = 0; i < 16; i++) load_word(i, 20'h49000);
    run_prog("full", 1'b0, 1'b0, 20'h0);

    // HALT at address 0.
    load_word(0, 20'h00000);
    run_prog("halt0", 1'b0, 1'b0, 20'h0);

    // Write to address 0 on the same edge as start.
    run_prog("start_wr0", 1'b0, 1'b1, 20'h8B123);

    // Reset in the middle of a loadR hold.
    load_word(0, 20'h8A000);
    load_word(1, 20'h49000);
    load_word(2, 20'h00000);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("mid busy before rst", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_values("mid_rst async");
    @(posedge clk);
    #1;
    chk_reset_values("mid_rst held");
    @(negedge clk);
    rst = 1'b1;
    run_prog("after_rst", 1'b0, 1'b0, 20'h0);

    // Randomized programs.
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(0, 16);
      for (int i = 0; i < 16; i++) begin
        logic [19:0] w;
        w = 20'($urandom);
        if (i < len) w[19:18] = 2'($urandom_range(1, 3));
        else         w[19:18] = 2'b00;
        load_word(i, w);
      end
      run_prog($sformatf("rand%0d", t), ($urandom_range(0, 1) == 1), 1'b0, 20'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
